// File: rtl/osnt_bram_capture_writer_if.sv
// AXI4-Stream tap bundle feeding the BRAM capture writer.
interface osnt_bram_capture_writer_if #(
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TUSER_WIDTH = 128
);
  localparam int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (
    output tdata, tkeep, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/osnt_bram_capture_writer.sv
// Packet capture stage: taps an AXI4-Stream and writes whole packets as packed
// words to sequential BRAM addresses under host arm/clear control.
module osnt_bram_capture_writer #(
  parameter int unsigned ADDR_WIDTH           = 20,
  parameter int unsigned DATA_WIDTH           = 800,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                    axis_aclk,
  input  logic                    axis_resetn,
  osnt_bram_capture_writer_if.slave s_axis,
  input  logic                    cap_start,
  input  logic                    cap_clear,
  input  logic [31:0]             cap_max_pkts,
  output logic                    cap_busy,
  output logic                    cap_done,
  output logic                    cap_trunc,
  output logic [31:0]             cap_pkt_count,
  output logic [ADDR_WIDTH:0]     cap_word_count,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_wrdata,
  output logic                    bram_en,
  output logic                    bram_we
);

  localparam int unsigned KEEP_WIDTH = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned KEEP_FIELD = 128;
  localparam int unsigned TUSER_LO   = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned KEEP_LO    = TUSER_LO + C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned VALID_BIT  = KEEP_LO + KEEP_FIELD;
  localparam int unsigned LAST_BIT   = VALID_BIT + 1;
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  // Word layout: tdata | tuser | zero-extended tkeep | tvalid | tlast | zero pad.
  function automatic logic [DATA_WIDTH-1:0] pack_word(
    input logic [C_S_AXIS_DATA_WIDTH-1:0]  data,
    input logic [KEEP_WIDTH-1:0]           keep,
    input logic [C_S_AXIS_TUSER_WIDTH-1:0] user,
    input logic                            last
  );
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    w[TUSER_LO-1:0]        = data;
    w[KEEP_LO-1:TUSER_LO]  = user;
    w[VALID_BIT-1:KEEP_LO] = KEEP_FIELD'(keep);
    w[VALID_BIT]           = 1'b1;
    w[LAST_BIT]            = last;
    return w;
  endfunction

  state_e                state_q, state_d;
  logic                  in_pkt_q, in_pkt_d;
  logic                  tready_q;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  trunc_q, trunc_d;
  logic [31:0]           max_q, max_d;
  logic [31:0]           pkt_count_q, pkt_count_d;
  logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                  beat_c;
  logic                  write_c;
  logic                  full_c;
  logic [31:0]           pkt_inc_c;

  assign beat_c    = s_axis.tvalid & tready_q;
  assign full_c    = (word_count_q == LAST_ADDR);
  assign pkt_inc_c = pkt_count_q + 32'd1;

  // Next-state: control FSM, counters and the single write-stage register.
  always_comb begin
    state_d      = state_q;
    in_pkt_d     = in_pkt_q;
    trunc_d      = trunc_q;
    max_d        = max_q;
    pkt_count_d  = pkt_count_q;
    word_count_d = word_count_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    write_c      = 1'b0;

    if (beat_c) begin
      in_pkt_d = ~s_axis.tlast;
    end

    if (cap_clear) begin
      state_d      = ST_IDLE;
      trunc_d      = 1'b0;
      pkt_count_d  = '0;
      word_count_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cap_start) begin
            state_d      = ST_ARM;
            max_d        = cap_max_pkts;
            trunc_d      = 1'b0;
            pkt_count_d  = '0;
            word_count_d = '0;
          end
        end
        ST_ARM:     write_c = beat_c & ~in_pkt_q;
        ST_CAPTURE: write_c = beat_c;
        default:    state_d = ST_IDLE;
      endcase

      // A capture ends on the last BRAM address or on the requested packet count.
      if (write_c) begin
        wr_en_d      = 1'b1;
        wr_addr_d    = word_count_q[ADDR_WIDTH-1:0];
        wr_data_d    = pack_word(s_axis.tdata, s_axis.tkeep, s_axis.tuser, s_axis.tlast);
        word_count_d = word_count_q + CNT_WIDTH'(1);
        state_d      = ST_CAPTURE;
        if (full_c) begin
          wr_data_d[LAST_BIT] = 1'b1;
          state_d             = ST_DONE;
          if (!s_axis.tlast) begin
            trunc_d = 1'b1;
          end
        end
        if (s_axis.tlast || full_c) begin
          pkt_count_d = pkt_inc_c;
        end
        if (s_axis.tlast && (max_q != 32'd0) && (pkt_inc_c == max_q)) begin
          state_d = ST_DONE;
        end
      end
    end

    busy_d = (state_d == ST_ARM) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q      <= ST_IDLE;
      in_pkt_q     <= 1'b0;
      tready_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trunc_q      <= 1'b0;
      max_q        <= '0;
      pkt_count_q  <= '0;
      word_count_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      in_pkt_q     <= in_pkt_d;
      tready_q     <= 1'b1;
      busy_q       <= busy_d;
      done_q       <= done_d;
      trunc_q      <= trunc_d;
      max_q        <= max_d;
      pkt_count_q  <= pkt_count_d;
      word_count_q <= word_count_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign s_axis.tready  = tready_q;
  assign cap_busy       = busy_q;
  assign cap_done       = done_q;
  assign cap_trunc      = trunc_q;
  assign cap_pkt_count  = pkt_count_q;
  assign cap_word_count = word_count_q;
  assign bram_addr      = wr_addr_q;
  assign bram_wrdata    = wr_data_q;
  assign bram_en        = wr_en_q;
  assign bram_we        = wr_en_q;

endmodule

// File: tb/tb_osnt_bram_capture_writer.sv
// Directed bench for osnt_bram_capture_writer with a 16-word BRAM.
module tb_osnt_bram_capture_writer;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 800;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cap_start;
  logic          cap_clear;
  logic [31:0]   cap_max_pkts;
  logic          cap_busy;
  logic          cap_done;
  logic          cap_trunc;
  logic [31:0]   cap_pkt_count;
  logic [AW:0]   cap_word_count;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wrdata;
  logic          bram_en;
  logic          bram_we;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];

  always #5 clk = ~clk;

  osnt_bram_capture_writer_if #(.TDATA_WIDTH(512), .TUSER_WIDTH(128)) axis ();

  osnt_bram_capture_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .C_S_AXIS_DATA_WIDTH(512), .C_S_AXIS_TUSER_WIDTH(128)
  ) dut (
    .axis_aclk(clk), .axis_resetn(rst_n), .s_axis(axis),
    .cap_start(cap_start), .cap_clear(cap_clear), .cap_max_pkts(cap_max_pkts),
    .cap_busy(cap_busy), .cap_done(cap_done), .cap_trunc(cap_trunc),
    .cap_pkt_count(cap_pkt_count), .cap_word_count(cap_word_count),
    .bram_addr(bram_addr), .bram_wrdata(bram_wrdata),
    .bram_en(bram_en), .bram_we(bram_we)
  );

  // BRAM write recorder
  always @(negedge clk) begin
    if (bram_en === 1'b1) begin
      wq_addr.push_back(bram_addr);
      wq_data.push_back(bram_wrdata);
    end
  end

  function automatic logic [DW-1:0] exp_word(input logic [7:0] tag, input logic last, input logic force_last);
    logic [DW-1:0]  w;
    logic [511:0]   d;
    d = {64{tag}};
    w = '0;
    w[511:0]   = d;
    w[639:512] = {120'd0, tag};
    w[767:640] = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    w[768]     = 1'b1;
    w[769]     = last | force_last;
    return w;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      axis.tvalid = 1'b0;
      axis.tlast  = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic beat(input logic [7:0] tag, input logic last);
    axis.tvalid = 1'b1;
    axis.tlast  = last;
    axis.tdata  = {64{tag}};
    axis.tkeep  = '1;
    axis.tuser  = {120'd0, tag};
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [31:0] max);
    cap_max_pkts = max;
    cap_start    = 1'b1;
    idle(1);
    cap_start    = 1'b0;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (axis.tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready_low: got %b expected 0", axis.tready); end
    n_checks++; if (bram_en !== 1'b0) begin n_fail++; $display("FAIL rst_bram_en: got %b expected 0", bram_en); end
    n_checks++; if ({cap_busy, cap_done, cap_trunc} !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b expected 000", {cap_busy, cap_done, cap_trunc}); end
    n_checks++; if (cap_pkt_count !== 32'd0 || cap_word_count !== 5'd0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", cap_pkt_count, cap_word_count); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (axis.tready !== 1'b1) begin n_fail++; $display("FAIL rst_tready_high: got %b expected 1", axis.tready); end
  endtask

  task automatic test_max_pkts();
    logic [7:0] tags[4]  = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic       lasts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    clear_log();
    pulse_start(32'd2);
    n_checks++; if (cap_busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b expected 1", cap_busy); end
    cap_max_pkts = 32'd5;
    beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b1);
    beat(8'h04, 1'b1);
    beat(8'h05, 1'b0); beat(8'h06, 1'b1);
    idle(2);
    n_checks++; if (wq_data.size() !== 4) begin n_fail++; $display("FAIL t1_nwrites: got %0d expected 4", wq_data.size()); end
    for (int i = 0; i < 4 && i < wq_data.size(); i++) begin
      n_checks++; if (wq_addr[i] !== AW'(i)) begin n_fail++; $display("FAIL t1_addr%0d: got %0d expected %0d", i, wq_addr[i], i); end
      n_checks++; if (wq_data[i] !== exp_word(tags[i], lasts[i], 1'b0)) begin n_fail++; $display("FAIL t1_data%0d: got %0h expected %0h", i, wq_data[i][775:768], exp_word(tags[i], lasts[i], 1'b0)[775:768]); end
    end
    n_checks++; if (cap_pkt_count !== 32'd2) begin n_fail++; $display("FAIL t1_pkts: got %0d expected 2", cap_pkt_count); end
    n_checks++; if (cap_word_count !== 5'd4) begin n_fail++; $display("FAIL t1_words: got %0d expected 4", cap_word_count); end
    n_checks++; if ({cap_busy, cap_done, cap_trunc} !== 3'b010) begin n_fail++; $display("FAIL t1_status: got %b expected 010", {cap_busy, cap_done, cap_trunc}); end
  endtask

  task automatic test_start_mid_pkt();
    clear_log();
    beat(8'h10, 1'b0); beat(8'h11, 1'b0);
    pulse_start(32'd1);
    beat(8'h12, 1'b0); beat(8'h13, 1'b1);
    beat(8'h20, 1'b0);
    pulse_start(32'd1);
    beat(8'h21, 1'b1);
    idle(2);
    n_checks++; if (wq_data.size() !== 2) begin n_fail++; $display("FAIL t2_nwrites: got %0d expected 2", wq_data.size()); end
    if (wq_data.size() >= 2) begin
      n_checks++; if (wq_addr[0] !== 4'd0 || wq_data[0] !== exp_word(8'h20, 1'b0, 1'b0)) begin n_fail++; $display("FAIL t2_word0: got addr %0d tag %0h expected addr 0 tag 20", wq_addr[0], wq_data[0][7:0]); end
      n_checks++; if (wq_addr[1] !== 4'd1 || wq_data[1] !== exp_word(8'h21, 1'b1, 1'b0)) begin n_fail++; $display("FAIL t2_word1: got addr %0d tag %0h expected addr 1 tag 21", wq_addr[1], wq_data[1][7:0]); end
    end
    n_checks++; if (cap_pkt_count !== 32'd1 || cap_done !== 1'b1) begin n_fail++; $display("FAIL t2_end: got pkts %0d done %b expected 1/1", cap_pkt_count, cap_done); end
  endtask

  task automatic test_bram_full();
    cap_clear = 1'b1;
    idle(1);
    cap_clear = 1'b0;
    clear_log();
    pulse_start(32'd0);
    for (int i = 0; i < 20; i++) beat(8'h40 + 8'(i), (i == 19));
    idle(2);
    n_checks++; if (wq_data.size() !== 16) begin n_fail++; $display("FAIL t3_nwrites: got %0d expected 16", wq_data.size()); end
    for (int i = 0; i < 16 && i < wq_data.size(); i++) begin
      n_checks++; if (wq_addr[i] !== AW'(i)) begin n_fail++; $display("FAIL t3_addr%0d: got %0d expected %0d", i, wq_addr[i], i); end
      n_checks++; if (wq_data[i] !== exp_word(8'h40 + 8'(i), 1'b0, (i == 15))) begin n_fail++; $display("FAIL t3_data%0d: got tag %0h bit769 %b expected tag %0h bit769 %b", i, wq_data[i][7:0], wq_data[i][769], 8'h40 + 8'(i), (i == 15)); end
    end
    n_checks++; if (cap_trunc !== 1'b1) begin n_fail++; $display("FAIL t3_trunc: got %b expected 1", cap_trunc); end
    n_checks++; if (cap_word_count !== 5'd16) begin n_fail++; $display("FAIL t3_words: got %0d expected 16", cap_word_count); end
    n_checks++; if (cap_pkt_count !== 32'd1) begin n_fail++; $display("FAIL t3_pkts: got %0d expected 1", cap_pkt_count); end
    n_checks++; if (cap_done !== 1'b1 || cap_busy !== 1'b0) begin n_fail++; $display("FAIL t3_done: got done %b busy %b expected 1/0", cap_done, cap_busy); end
  endtask

  task automatic test_packing();
    logic [DW-1:0] w;
    logic [511:0]  a5;
    a5 = {64{8'hA5}};
    clear_log();
    pulse_start(32'd1);
    axis.tvalid = 1'b1;
    axis.tlast  = 1'b1;
    axis.tdata  = a5;
    axis.tkeep  = 64'h0000_FFFF;
    axis.tuser  = 128'h1234;
    @(negedge clk);
    idle(2);
    n_checks++; if (wq_data.size() !== 1) begin n_fail++; $display("FAIL t4_nwrites: got %0d expected 1", wq_data.size()); end
    w = (wq_data.size() > 0) ? wq_data[0] : '0;
    n_checks++; if (w[511:0] !== a5) begin n_fail++; $display("FAIL t4_tdata: got %0h expected %0h", w[511:0], a5); end
    n_checks++; if (w[639:512] !== 128'h1234) begin n_fail++; $display("FAIL t4_tuser: got %0h expected 1234", w[639:512]); end
    n_checks++; if (w[767:640] !== 128'h0000_FFFF) begin n_fail++; $display("FAIL t4_tkeep: got %0h expected ffff", w[767:640]); end
    n_checks++; if (w[769:768] !== 2'b11) begin n_fail++; $display("FAIL t4_flags: got %b expected 11", w[769:768]); end
    n_checks++; if (w[799:770] !== 30'd0) begin n_fail++; $display("FAIL t4_pad: got %0h expected 0", w[799:770]); end
  endtask

  task automatic test_clear();
    clear_log();
    pulse_start(32'd0);
    beat(8'h60, 1'b0); beat(8'h61, 1'b0);
    cap_clear = 1'b1;
    beat(8'h62, 1'b0);
    cap_clear = 1'b0;
    idle(2);
    n_checks++; if (wq_data.size() !== 2) begin n_fail++; $display("FAIL t5_nwrites: got %0d expected 2", wq_data.size()); end
    n_checks++; if ({cap_busy, cap_done, cap_trunc} !== 3'b000) begin n_fail++; $display("FAIL t5_status: got %b expected 000", {cap_busy, cap_done, cap_trunc}); end
    n_checks++; if (cap_pkt_count !== 32'd0 || cap_word_count !== 5'd0) begin n_fail++; $display("FAIL t5_counts: got %0d/%0d expected 0/0", cap_pkt_count, cap_word_count); end
    beat(8'h63, 1'b1);
    pulse_start(32'd0);
    beat(8'h70, 1'b1);
    idle(1);
    n_checks++; if (wq_data.size() !== 3) begin n_fail++; $display("FAIL t5_rearm_n: got %0d expected 3", wq_data.size()); end
    if (wq_data.size() == 3) begin
      n_checks++; if (wq_addr[2] !== 4'd0 || wq_data[2] !== exp_word(8'h70, 1'b1, 1'b0)) begin n_fail++; $display("FAIL t5_rearm_word: got addr %0d tag %0h expected addr 0 tag 70", wq_addr[2], wq_data[2][7:0]); end
    end
    n_checks++; if (cap_pkt_count !== 32'd1 || cap_busy !== 1'b1) begin n_fail++; $display("FAIL t5_rearm_state: got pkts %0d busy %b expected 1/1", cap_pkt_count, cap_busy); end
  endtask

  task automatic test_async_reset();
    axis.tvalid = 1'b1;
    axis.tlast  = 1'b0;
    axis.tdata  = {64{8'h71}};
    axis.tuser  = 128'h71;
    @(posedge clk);
    #1;
    n_checks++; if (bram_en !== 1'b1) begin n_fail++; $display("FAIL t6_pre_en: got %b expected 1", bram_en); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bram_en !== 1'b0) begin n_fail++; $display("FAIL t6_async_en: got %b expected 0", bram_en); end
    n_checks++; if (cap_busy !== 1'b0) begin n_fail++; $display("FAIL t6_async_busy: got %b expected 0", cap_busy); end
    axis.tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (axis.tready !== 1'b1) begin n_fail++; $display("FAIL t6_tready: got %b expected 1", axis.tready); end
    n_checks++; if ({cap_busy, cap_done, cap_trunc} !== 3'b000) begin n_fail++; $display("FAIL t6_status: got %b expected 000", {cap_busy, cap_done, cap_trunc}); end
    n_checks++; if (cap_pkt_count !== 32'd0 || cap_word_count !== 5'd0) begin n_fail++; $display("FAIL t6_counts: got %0d/%0d expected 0/0", cap_pkt_count, cap_word_count); end
  endtask

  initial begin
    rst_n        = 1'b0;
    cap_start    = 1'b0;
    cap_clear    = 1'b0;
    cap_max_pkts = '0;
    axis.tvalid  = 1'b0;
    axis.tlast   = 1'b0;
    axis.tdata   = '0;
    axis.tkeep   = '0;
    axis.tuser   = '0;
    @(negedge clk);
    test_reset();
    test_max_pkts();
    test_start_mid_pkt();
    test_bram_full();
    test_packing();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
